chacha_aead_seq: RTL

Job-level sequencer that drives `chacha20_poly1305_core` through one complete AEAD operation. The sequence is: configure, keystream request, AAD stream, payload stream, length block, tag collection. It sits between the host/DMA front-end and the core. It forwards upstream 128-bit beats with generated byte-keep masks, builds the length block, and combines the two core tag halves into the final tag.

---
 rtl/chacha_aead_seq.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/chacha_aead_seq.sv
`default_nettype none
// ============================================================================
// Module   : chacha_aead_seq
// Brief    : Job sequencer driving chacha20_poly1305_core through one AEAD op.
//            Optional tag check enabled by defining CHACHA_SEQ_TAGCHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module chacha_aead_seq #(
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [255:0]     job_key,
    input  logic [95:0]      job_nonce,
    input  logic [31:0]      job_ctr,
    input  logic             job_algo,
    input  logic [LEN_W-1:0] job_aad_len,
    input  logic [LEN_W-1:0] job_pld_len,
`ifdef CHACHA_SEQ_TAGCHK_EN
    input  logic [127:0]     exp_tag,
    input  logic             chk_en,
    output logic             tag_ok,
`endif
    input  logic             s_aad_valid,
    input  logic [127:0]     s_aad_data,
    output logic             s_aad_ready,
    input  logic             s_pld_valid,
    input  logic [127:0]     s_pld_data,
    output logic             s_pld_ready,
    output logic [255:0]     key,
    output logic [95:0]      nonce,
    output logic [31:0]      ctr_init,
    output logic             algo_sel,
    output logic             cfg_we,
    output logic             ks_req,
    input  logic             ks_valid,
    output logic             aad_valid,
    output logic [127:0]     aad_data,
    output logic [15:0]      aad_keep,
    input  logic             aad_ready,
    output logic             pld_valid,
    output logic [127:0]     pld_data,
    output logic [15:0]      pld_keep,
    input  logic             pld_ready,
    output logic             len_valid,
    output logic [127:0]     len_block,
    input  logic             len_ready,
    input  logic [127:0]     tag_pre_xor,
    input  logic             tag_pre_xor_valid,
    input  logic [127:0]     tagmask,
    input  logic             tagmask_valid,
    output logic             busy,
    output logic             done,
    output logic [127:0]     tag,
    output logic             tag_valid
);

    localparam logic [3:0] C_IDLE   = 4'd0;
    localparam logic [3:0] C_CFG    = 4'd1;
    localparam logic [3:0] C_KSREQ  = 4'd2;
    localparam logic [3:0] C_KSWAIT = 4'd3;
    localparam logic [3:0] C_AAD    = 4'd4;
    localparam logic [3:0] C_PLD    = 4'd5;
    localparam logic [3:0] C_LEN    = 4'd6;
    localparam logic [3:0] C_TAG    = 4'd7;
    localparam logic [3:0] C_DONE   = 4'd8;

    localparam logic [15:0]      C_KEEP_ALL = 16'hFFFF;
    localparam logic [LEN_W-1:0] C_ONE      = LEN_W'(1);

    logic [3:0]       r_state;
    logic [3:0]       w_state_nxt;
    logic [LEN_W-1:0] r_aad_len;
    logic [LEN_W-1:0] r_pld_len;
    logic [LEN_W-1:0] r_aad_left;
    logic [LEN_W-1:0] r_pld_left;
    logic [127:0]     r_pre;
    logic [127:0]     r_mask;
    logic             r_pre_v;
    logic             r_mask_v;

    logic             w_aad_hs;
    logic             w_pld_hs;
    logic             w_aad_last;
    logic             w_pld_last;
    logic [15:0]      w_aad_keep_last;
    logic [15:0]      w_pld_keep_last;
    logic [127:0]     w_pre_val;
    logic [127:0]     w_mask_val;
    logic             w_tag_both;
    logic [127:0]     w_tag;

`ifdef CHACHA_SEQ_TAGCHK_EN
    logic [127:0]     r_exp_tag;
    logic             r_chk_en;
`endif

    // Beats per stream: ceil(len/16) without risking overflow of len+15.
    function automatic logic [LEN_W-1:0] beats(input logic [LEN_W-1:0] len);
        return (len >> 4) + LEN_W'(|len[3:0]);
    endfunction

    function automatic logic [15:0] last_keep(input logic [3:0] rem);
        return (rem == 4'd0) ? C_KEEP_ALL : ((16'h1 << rem) - 16'h1);
    endfunction

    always_comb begin
        w_aad_hs        = (r_state == C_AAD) && s_aad_valid && aad_ready;
        w_pld_hs        = (r_state == C_PLD) && s_pld_valid && pld_ready;
        w_aad_last      = w_aad_hs && (r_aad_left == C_ONE);
        w_pld_last      = w_pld_hs && (r_pld_left == C_ONE);
        w_aad_keep_last = last_keep(r_aad_len[3:0]);
        w_pld_keep_last = last_keep(r_pld_len[3:0]);

        // A half arriving this cycle counts as held so done follows in one cycle.
        w_pre_val  = tag_pre_xor_valid ? tag_pre_xor : r_pre;
        w_mask_val = tagmask_valid ? tagmask : r_mask;
        w_tag_both = (r_state == C_TAG) && (r_pre_v || tag_pre_xor_valid)
                     && (r_mask_v || tagmask_valid);
        w_tag      = algo_sel ? (w_pre_val + w_mask_val) : (w_pre_val ^ w_mask_val);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_IDLE:   if (start) w_state_nxt = C_CFG;
            C_CFG:    w_state_nxt = C_KSREQ;
            C_KSREQ:  w_state_nxt = C_KSWAIT;
            C_KSWAIT: begin
                if (ks_valid) begin
                    if (r_aad_len != '0)      w_state_nxt = C_AAD;
                    else if (r_pld_len != '0) w_state_nxt = C_PLD;
                    else                      w_state_nxt = C_LEN;
                end
            end
            C_AAD:    if (w_aad_last) w_state_nxt = (r_pld_len != '0) ? C_PLD : C_LEN;
            C_PLD:    if (w_pld_last) w_state_nxt = C_LEN;
            C_LEN:    if (len_ready) w_state_nxt = C_TAG;
            C_TAG:    if (w_tag_both) w_state_nxt = C_DONE;
            C_DONE:   w_state_nxt = C_IDLE;
            default:  w_state_nxt = C_IDLE;
        endcase
        if (abort) w_state_nxt = C_IDLE;
    end

    always_comb begin
        busy        = (r_state != C_IDLE);
        done        = (r_state == C_DONE);
        cfg_we      = (r_state == C_CFG);
        ks_req      = (r_state == C_KSREQ);
        len_valid   = (r_state == C_LEN);

        aad_valid   = (r_state == C_AAD) && s_aad_valid;
        s_aad_ready = (r_state == C_AAD) && aad_ready;
        aad_data    = (r_state == C_AAD) ? s_aad_data : '0;
        aad_keep    = (r_state != C_AAD) ? 16'h0000 :
                      (r_aad_left == C_ONE) ? w_aad_keep_last : C_KEEP_ALL;

        pld_valid   = (r_state == C_PLD) && s_pld_valid;
        s_pld_ready = (r_state == C_PLD) && pld_ready;
        pld_data    = (r_state == C_PLD) ? s_pld_data : '0;
        pld_keep    = (r_state != C_PLD) ? 16'h0000 :
                      (r_pld_left == C_ONE) ? w_pld_keep_last : C_KEEP_ALL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= C_IDLE;
            r_aad_len  <= '0;
            r_pld_len  <= '0;
            r_aad_left <= '0;
            r_pld_left <= '0;
            r_pre      <= '0;
            r_mask     <= '0;
            r_pre_v    <= 1'b0;
            r_mask_v   <= 1'b0;
            key        <= '0;
            nonce      <= '0;
            ctr_init   <= '0;
            algo_sel   <= 1'b0;
            len_block  <= '0;
            tag        <= '0;
            tag_valid  <= 1'b0;
`ifdef CHACHA_SEQ_TAGCHK_EN
            r_exp_tag  <= '0;
            r_chk_en   <= 1'b0;
            tag_ok     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (abort) begin
                r_aad_left <= '0;
                r_pld_left <= '0;
                r_pre_v    <= 1'b0;
                r_mask_v   <= 1'b0;
                tag_valid  <= 1'b0;
`ifdef CHACHA_SEQ_TAGCHK_EN
                tag_ok     <= 1'b0;
`endif
            end else begin
                if ((r_state == C_IDLE) && start) begin
                    r_aad_len  <= job_aad_len;
                    r_pld_len  <= job_pld_len;
                    r_aad_left <= beats(job_aad_len);
                    r_pld_left <= beats(job_pld_len);
                    key        <= job_key;
                    nonce      <= job_nonce;
                    ctr_init   <= job_ctr;
                    algo_sel   <= job_algo;
                    len_block  <= {64'(job_pld_len), 64'(job_aad_len)};
                    r_pre_v    <= 1'b0;
                    r_mask_v   <= 1'b0;
                    tag_valid  <= 1'b0;
`ifdef CHACHA_SEQ_TAGCHK_EN
                    r_exp_tag  <= exp_tag;
                    r_chk_en   <= chk_en;
                    tag_ok     <= 1'b0;
`endif
                end
                if (w_aad_hs) r_aad_left <= r_aad_left - C_ONE;
                if (w_pld_hs) r_pld_left <= r_pld_left - C_ONE;
                if (r_state == C_TAG) begin
                    if (tag_pre_xor_valid) begin
                        r_pre   <= tag_pre_xor;
                        r_pre_v <= 1'b1;
                    end
                    if (tagmask_valid) begin
                        r_mask   <= tagmask;
                        r_mask_v <= 1'b1;
                    end
                end
                if (w_tag_both) begin
                    tag       <= w_tag;
                    tag_valid <= 1'b1;
`ifdef CHACHA_SEQ_TAGCHK_EN
                    // Full-width equality in a single cycle keeps the check constant-time.
                    tag_ok    <= r_chk_en && (w_tag == r_exp_tag);
`endif
                end
            end
        end
    end

endmodule
`default_nettype wire
